// File: rtl/leading_one_pkg.sv
// leading_one_pkg: shared types and helpers for the leading-one scanner.
//   state_t  : scanner FSM state (IDLE, SCAN)
//   idx_w()  : index width for a given word width (clog2, minimum 1)
package leading_one_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int unsigned idx_w(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/leading_one_enc.sv
// leading_one_enc: combinational priority encoder.
//   i_vec    in   WIDTH  vector to encode
//   o_idx    out  IDX_W  position of the winning set bit (0 when none)
//   o_any    out  1      at least one bit of i_vec is set
//   o_onehot out  WIDTH  the winning bit isolated (all zeros when none)
// MSB_FIRST=1 picks the highest set bit, MSB_FIRST=0 the lowest.
module leading_one_enc
   import leading_one_pkg::*;
#(
   parameter int unsigned WIDTH     = 9,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned IDX_W    = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any,
   output logic [WIDTH-1:0] o_onehot
);

   always_comb begin
      int unsigned j;
      j        = 0;
      o_idx    = '0;
      o_any    = 1'b0;
      o_onehot = '0;
      // Later hits overwrite earlier ones, so walk toward the winning end.
      for (int unsigned n = 0; n < WIDTH; n++) begin
         j = MSB_FIRST ? n : (WIDTH - 1 - n);
         if (i_vec[j]) begin
            o_idx       = IDX_W'(j);
            o_any       = 1'b1;
            o_onehot    = '0;
            o_onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/leading_one_scanner.sv
// leading_one_scanner: streaming set-bit scanner.
// Accepts one word per valid/ready handshake and emits the index of every set bit, one per
// output beat, in priority order (highest first when MSB_FIRST=1, lowest first otherwise).
// A zero word yields a single beat with out_zero=1.
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   in_valid   in   1        in_data valid
//   in_ready   out  1        word can be accepted this cycle
//   in_data    in   WIDTH    word to scan
//   out_valid  out  1        beat valid
//   out_ready  in   1        consumer takes the current beat
//   out_index  out  IDX_W    bit position of the current set bit (0 for a zero word)
//   out_zero   out  1        accepted word was all zeros
//   out_last   out  1        final beat of the current word
//   out_popcnt out  IDX_W+1  set-bit count of the word (only with LEADING_ONE_POPCNT_EN)
// Build option: define LEADING_ONE_POPCNT_EN to add the out_popcnt port and its register.
module leading_one_scanner
   import leading_one_pkg::*;
#(
   parameter int unsigned WIDTH     = 9,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned IDX_W    = idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_zero,
   output logic             out_last
`ifdef LEADING_ONE_POPCNT_EN
   ,
   output logic [IDX_W:0]   out_popcnt
`endif
);

   state_t             r_state;
   state_t             w_state_d;
   logic [WIDTH-1:0]   r_residue;
   logic [WIDTH-1:0]   w_residue_d;
   logic               r_zero;
   logic               w_zero_d;

   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [WIDTH-1:0]   w_onehot;
   logic               w_in_hs;
   logic               w_out_hs;

   leading_one_enc #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_enc (
      .i_vec    (r_residue),
      .o_idx    (w_idx),
      .o_any    (w_any),
      .o_onehot (w_onehot)
   );

   assign out_valid = (r_state == SCAN);
   assign out_index = w_any ? w_idx : '0;
   assign out_zero  = r_zero;
   // Last beat when only the reported bit remains; a zero word is a single beat.
   assign out_last  = out_valid & (r_zero | ((r_residue & ~w_onehot) == '0));

   assign w_out_hs  = out_valid & out_ready;
   // Accepting during the final beat gives back-to-back words without a bubble.
   assign in_ready  = ~rst & ((r_state == IDLE) | (w_out_hs & out_last));
   assign w_in_hs   = in_valid & in_ready;

   always_comb begin
      w_state_d   = r_state;
      w_residue_d = r_residue;
      w_zero_d    = r_zero;

      unique case (r_state)
         IDLE: if (w_in_hs) w_state_d = SCAN;
         SCAN: if (w_out_hs && out_last) w_state_d = w_in_hs ? SCAN : IDLE;
         default: w_state_d = IDLE;
      endcase

      if (w_out_hs) begin
         // On the last beat this also empties the residue.
         w_residue_d = r_residue & ~w_onehot;
         if (out_last) w_zero_d = 1'b0;
      end

      // A new word overrides the clear of the finishing one.
      if (w_in_hs) begin
         w_residue_d = in_data;
         w_zero_d    = (in_data == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_residue <= '0;
         r_zero    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_residue <= w_residue_d;
         r_zero    <= w_zero_d;
      end
   end

`ifdef LEADING_ONE_POPCNT_EN
   logic [IDX_W:0] r_popcnt;
   logic [IDX_W:0] w_popcnt_in;

   always_comb begin
      w_popcnt_in = '0;
      for (int unsigned n = 0; n < WIDTH; n++) begin
         w_popcnt_in = w_popcnt_in + (IDX_W + 1)'(in_data[n]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_popcnt <= '0;
      end else if (w_in_hs) begin
         r_popcnt <= w_popcnt_in;
      end
   end

   assign out_popcnt = r_popcnt;
`endif

endmodule

// File: tb/tb_leading_one_scanner.sv
// Self-checking bench for leading_one_scanner (WIDTH=9). Two instances share the same
// stimulus: dut 0 scans MSB first, dut 1 LSB first. Accepted words are queued; a monitor
// derives each expected beat from the word by ranking its set bits.
module tb_leading_one_scanner;

   localparam int W  = 9;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          out_ready;
   logic          rnd_ready = 1'b0;

   logic          ir [2];
   logic          ov [2];
   logic [IW-1:0] ix [2];
   logic          oz [2];
   logic          ol [2];
`ifdef LEADING_ONE_POPCNT_EN
   logic [IW:0]   pc [2];
`endif

   logic [W-1:0]  words [$];
   int            wptr [2];
   int            bptr [2];
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   leading_one_scanner #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[0]),
      .in_data   (in_data),
      .out_valid (ov[0]),
      .out_ready (out_ready),
      .out_index (ix[0]),
      .out_zero  (oz[0]),
      .out_last  (ol[0])
`ifdef LEADING_ONE_POPCNT_EN
      ,
      .out_popcnt(pc[0])
`endif
   );

   leading_one_scanner #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[1]),
      .in_data   (in_data),
      .out_valid (ov[1]),
      .out_ready (out_ready),
      .out_index (ix[1]),
      .out_zero  (oz[1]),
      .out_last  (ol[1])
`ifdef LEADING_ONE_POPCNT_EN
      ,
      .out_popcnt(pc[1])
`endif
   );

   // ---------------- reference model ----------------
   function automatic int beats_of(input logic [W-1:0] w);
      return (w == '0) ? 1 : $countones(w);
   endfunction

   // Position of the k-th set bit counted from the priority end.
   function automatic int kth_index(input logic [W-1:0] w, input int k, input bit msb);
      int c;
      int i;
      c = 0;
      for (int n = 0; n < W; n++) begin
         i = msb ? (W - 1 - n) : n;
         if (w[i]) begin
            if (c == k) return i;
            c++;
         end
      end
      return 0;
   endfunction

   function automatic int remaining(input int d);
      int r;
      r = 0;
      for (int p = wptr[d]; p < words.size(); p++) r += beats_of(words[p]);
      return r - bptr[d];
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d, got, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      int          rem;
      logic [W-1:0] w;
      int          k;
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            rem = remaining(d);
            chk("out_valid", d, 32'(ov[d]), 32'(rem > 0));
            chk("in_ready", d, 32'(ir[d]), 32'((rem == 0) || (rem == 1 && out_ready)));
            if (ov[d] && rem > 0) begin
               w = words[wptr[d]];
               k = bptr[d];
               chk("out_index", d, 32'(ix[d]), 32'(kth_index(w, k, d == 0)));
               chk("out_zero", d, 32'(oz[d]), 32'(w == '0));
               chk("out_last", d, 32'(ol[d]), 32'(k == beats_of(w) - 1));
`ifdef LEADING_ONE_POPCNT_EN
               chk("out_popcnt", d, 32'(pc[d]), 32'($countones(w)));
`endif
               if (out_ready) begin
                  bptr[d]++;
                  if (bptr[d] == beats_of(w)) begin
                     wptr[d]++;
                     bptr[d] = 0;
                  end
               end
            end
         end
         if (in_valid && ir[0]) words.push_back(in_data);
      end
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [W-1:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n        = 0;
      @(negedge clk);
      while (!ir[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: word %0h not accepted within %0d cycles", w, n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((remaining(0) > 0 || remaining(1) > 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", remaining(0));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_valid"}, d, 32'(ov[d]), 32'(0));
         chk({nm, "_index"}, d, 32'(ix[d]), 32'(0));
         chk({nm, "_zero"},  d, 32'(oz[d]), 32'(0));
         chk({nm, "_last"},  d, 32'(ol[d]), 32'(0));
         chk({nm, "_ready"}, d, 32'(ir[d]), 32'(0));
`ifdef LEADING_ONE_POPCNT_EN
         chk({nm, "_popcnt"}, d, 32'(pc[d]), 32'(0));
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      wptr[0]   = 0;
      wptr[1]   = 0;
      bptr[0]   = 0;
      bptr[1]   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      #2;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) chk("ready_after_reset", d, 32'(ir[d]), 32'(1));
      @(posedge clk);
      #1;

      // Three set bits, free-running consumer.
      send(9'h124);
      drain();

      // Zero word.
      send(9'h000);
      drain();

      // Backpressure for three cycles on the first beat.
      out_ready = 1'b0;
      send(9'h003);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Back-to-back words accepted during the last beat.
      send(9'h100);
      send(9'h001);
      drain();

      // Reset after the first beat of an all-ones word.
      send(9'h1FF);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_valid", d, 32'(ov[d]), 32'(0));
         chk("rst_ready", d, 32'(ir[d]), 32'(0));
         wptr[d] = words.size();
         bptr[d] = 0;
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(9'h010);
      drain();

      // Full sweep with random gaps and random backpressure.
      rnd_ready = 1'b1;
      for (int v = 0; v < 512; v++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send(W'(v));
      end
      drain();
      rnd_ready = 1'b0;
      #2;
      out_ready = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
